// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer.
//   ROB_ENTRIES : default number of buffer entries
//   ROB_XLEN    : data/address width held in each entry
//   EXC_NONE    : exception code meaning "no exception"
//   rob_entry_t : one buffer entry
package rob_pkg;

  localparam int unsigned ROB_ENTRIES = 16;
  localparam int unsigned ROB_XLEN    = 32;

  localparam logic [2:0] EXC_NONE = 3'd0;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic                is_store;
    logic [4:0]          rd;
    logic [ROB_XLEN-1:0] pc;
    logic [ROB_XLEN-1:0] data;
    logic [2:0]          exception;
    logic [ROB_XLEN-1:0] addr;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer.
// Decode allocates at the tail, EX/MEM complete entries by index in any order,
// and the head retires strictly in program order. An excepting head retires
// with a one-cycle exception pulse and wipes the buffer, as does in_flush.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   in_allocate*              : allocation request (rd, store flag, pc)
//   out_allocate_idx/out_full : tail index handed to decode / stall
//   in_complete_*             : completion by index with result/exception/address
//   in_flush                  : wipe the buffer
//   out_commit_*              : register-file write / store drain at the head
//   out_exception_*           : precise exception report at commit
//   out_empty                 : no valid entries
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int unsigned ENTRIES = ROB_ENTRIES,
  parameter int unsigned XLEN    = ROB_XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_allocate,
  input  logic [4:0]                 in_allocate_rd,
  input  logic                       in_allocate_is_store,
  input  logic [XLEN-1:0]            in_allocate_pc,
  output logic [$clog2(ENTRIES)-1:0] out_allocate_idx,
  output logic                       out_full,
  input  logic                       in_complete_valid,
  input  logic [$clog2(ENTRIES)-1:0] in_complete_idx,
  input  logic [XLEN-1:0]            in_complete_data,
  input  logic [2:0]                 in_complete_exception,
  input  logic [XLEN-1:0]            in_complete_addr_miss,
  input  logic                       in_flush,
  output logic                       out_commit_valid,
  output logic                       out_commit_write_enable,
  output logic [4:0]                 out_commit_rd,
  output logic [XLEN-1:0]            out_commit_data,
  output logic                       out_commit_store,
  output logic [2:0]                 out_exception_vector,
  output logic [XLEN-1:0]            out_exception_pc,
  output logic [XLEN-1:0]            out_exception_addr,
  output logic                       out_empty
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned CntW = IdxW + 1;

  rob_entry_t            entries_q [ENTRIES];
  rob_entry_t            entries_d [ENTRIES];
  logic       [IdxW-1:0] head_q, head_d;
  logic       [IdxW-1:0] tail_q, tail_d;
  logic       [CntW-1:0] count_q, count_d;

  rob_entry_t head_entry;
  logic       commit_fire;
  logic       commit_exc;
  logic       alloc_ok;

  assign head_entry  = entries_q[head_q];
  assign commit_fire = head_entry.valid && head_entry.done;
  assign commit_exc  = commit_fire && (head_entry.exception != EXC_NONE);

  // Full is judged on the registered count, so a slot freed by this cycle's
  // commit only becomes usable next cycle.
  assign out_full         = (count_q == CntW'(ENTRIES));
  assign out_empty        = (count_q == '0);
  assign out_allocate_idx = tail_q;
  assign alloc_ok         = in_allocate && !out_full;

  always_comb begin
    out_commit_valid        = commit_fire;
    out_commit_write_enable = commit_fire && !commit_exc && !head_entry.is_store &&
                              (head_entry.rd != 5'd0);
    out_commit_store        = commit_fire && !commit_exc && head_entry.is_store;
    out_commit_rd           = '0;
    out_commit_data         = '0;
    out_exception_vector    = EXC_NONE;
    out_exception_pc        = '0;
    out_exception_addr      = '0;
    if (commit_fire) begin
      out_commit_rd   = head_entry.rd;
      out_commit_data = XLEN'(head_entry.data);
    end
    if (commit_exc) begin
      out_exception_vector = head_entry.exception;
      out_exception_pc     = XLEN'(head_entry.pc);
      out_exception_addr   = XLEN'(head_entry.addr);
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (in_flush || commit_exc) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Order matters: completion, then commit clear, then allocate. The
      // allocating tail slot is always invalid, so a completion aimed at it
      // is dropped and cannot corrupt the new entry.
      if (in_complete_valid && entries_q[in_complete_idx].valid) begin
        entries_d[in_complete_idx].done      = 1'b1;
        entries_d[in_complete_idx].data      = ROB_XLEN'(in_complete_data);
        entries_d[in_complete_idx].exception = in_complete_exception;
        entries_d[in_complete_idx].addr      = ROB_XLEN'(in_complete_addr_miss);
      end
      if (commit_fire) begin
        entries_d[head_q] = '0;
        head_d            = head_q + IdxW'(1);
        count_d           = count_d - CntW'(1);
      end
      if (alloc_ok) begin
        entries_d[tail_q]          = '0;
        entries_d[tail_q].valid    = 1'b1;
        entries_d[tail_q].rd       = in_allocate_rd;
        entries_d[tail_q].is_store = in_allocate_is_store;
        entries_d[tail_q].pc       = ROB_XLEN'(in_allocate_pc);
        tail_d                     = tail_q + IdxW'(1);
        count_d                    = count_d + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer that answers the decode stage's allocation requests and drives the register-file write port. Decode allocates an entry per instruction that writes back or stores. EX/MEM mark entries complete out of order. The buffer commits from the head strictly in program order, raises precise exceptions at commit, and wipes itself on flush.

## Interface
Parameters:
- ENTRIES, 16, number of entries; power of two; index width IDX_W = log2(ENTRIES) (4 at default)
- XLEN, 32, data/address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_allocate  in  1  decode requests an entry this cycle
- in_allocate_rd  in  5  destination register of the allocating instruction
- in_allocate_is_store  in  1  entry is a store (no register write; drains the store buffer at commit)
- in_allocate_pc  in  XLEN  PC of the allocating instruction
- out_allocate_idx  out  IDX_W  tail index handed to decode; valid whenever out_full is low
- out_full  out  1  no free entry; decode must stall
- in_complete_valid  in  1  an entry finishes this cycle
- in_complete_idx  in  IDX_W  index of the finishing entry
- in_complete_data  in  XLEN  result value
- in_complete_exception  in  3  exception vector; 0 means none
- in_complete_addr_miss  in  XLEN  faulting address for memory exceptions
- in_flush  in  1  taken branch / external wipe
- out_commit_valid  out  1  head entry retires this cycle
- out_commit_write_enable  out  1  register-file write enable (to decode in_write_enable)
- out_commit_rd  out  5  register-file write index
- out_commit_data  out  XLEN  register-file write data
- out_commit_store  out  1  head is a store retiring; store buffer drains one entry
- out_exception_vector  out  3  nonzero for one cycle when the head retires with an exception
- out_exception_pc  out  XLEN  PC of the excepting instruction
- out_exception_addr  out  XLEN  faulting address of the excepting instruction
- out_empty  out  1  no valid entries

## Operation
- State: per-entry valid, done, rd, is_store, pc, data, exception, addr; head and tail pointers (IDX_W bits, wrap modulo ENTRIES); count (IDX_W+1 bits, 0..ENTRIES).
- Allocate: if in_allocate and !out_full and !in_flush, write entry at tail (valid=1, done=0), tail+1, count+1.
- Complete: if in_complete_valid and entry[in_complete_idx].valid, set done and store data/exception/addr. A completion to an invalid entry is ignored.
- Commit (combinational outputs from the head): commit fires when head entry is valid and done.
  - exception==0: out_commit_valid=1. out_commit_write_enable=!is_store && rd!=0. out_commit_store=is_store. At the edge: clear the entry, head+1, count-1.
  - exception!=0: out_commit_valid=1, write enable and store low, out_exception_* driven. At the edge: the entire buffer is cleared as for a flush.
- Flush: in_flush clears all valid bits and sets head=tail=0, count=0. It overrides allocate, complete and commit in the same cycle. Commit outputs are still driven combinationally that cycle.
- Simultaneous events:
  - Allocate and commit in the same cycle leave count unchanged.
  - out_full is count==ENTRIES, evaluated before commit. A same-cycle freed slot is not reusable until the next cycle.
  - Completion of the current head in cycle N commits in cycle N+1, never in N.
- out_empty = (count==0).

## Timing
- Reset values: all outputs 0 except out_allocate_idx=0, out_full=0, out_empty=1.
- Allocate to index visible: out_allocate_idx advances one cycle after an accepted allocation.
- Complete to commit: minimum 1 cycle; the complete edge is at N and the commit outputs are high in N+1.
- Commit to the register file: the write occurs at the edge ending the commit cycle.
- The exception pulse lasts exactly one cycle. The buffer is empty in the following cycle.
- Throughput: one allocate, one complete and one commit per cycle.
- Reset is asynchronous: asserting it mid-operation clears state immediately, and no commit fires during reset.

## Structure
- Shared package rob_pkg:
  - rob_entry_t struct (valid, done, is_store, rd, pc, data, exception, addr)
  - EXC_NONE = 3'd0
  - ENTRIES default
- Single module, no sub-module. Entry array is flops, not RAM, because of the random-index complete write and the full clear on flush.

## Test plan
- Reset, then allocate rd=5, complete idx 0 data 0xDEADBEEF -> commit in the next cycle with we=1, rd=5, data=0xDEADBEEF; out_empty=1 afterwards.
- Allocate idx0 (rd=1) and idx1 (rd=2); complete idx1 first, then idx0 two cycles later -> rd=1 commits before rd=2, no commit while only idx1 is done.
- 16 allocations -> out_full=1 and the 17th is ignored. Commit one -> out_full drops a cycle later, and the next allocation receives the wrapped index 0.
- Allocate a store and an rd=0 instruction, complete both -> the store gives out_commit_store=1 with we=0; rd=0 gives we=0.
- Three entries; head completes with exception 3'd2, addr 0x100, pc 0x40 -> out_exception_vector=2, pc=0x40, addr=0x100 for one cycle; next cycle out_empty=1 and out_allocate_idx=0.
- in_flush with 5 pending entries plus a same-cycle allocate and complete -> buffer empty, allocate dropped; assert reset asynchronously mid-stream -> outputs at reset values before the next edge.
